// File: rtl/ex_mem_stage.sv
// Execute stage (forwarding muxes, ALU, destination mux, iterative HI/LO multiplier) plus EX/MEM register.
// Optional MULTU (opcode 1011) is compiled in when MD_UNSIGNED_EN is defined.
module ex_mem_stage #(
  parameter int          BITS_PER_CYCLE = 1,
  parameter logic [31:0] HILO_RST       = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic        ALUSrcE,
  input  logic        RegDstE,
  input  logic [3:0]  ALUControlE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] SignImmE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        MemWriteM,
  output logic [31:0] ALUOutM,
  output logic [31:0] WriteDataM,
  output logic [4:0]  WriteRegM,
  output logic        StallMdE
);

  localparam int MUL_LAT = 32 / BITS_PER_CYCLE;
  localparam int CW      = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(MUL_LAT - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_MFHI = 4'b1001;
  localparam logic [3:0] OP_MFLO = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic {ST_IDLE, ST_BUSY} md_state_t;

  logic [31:0] src_a;
  logic [31:0] fwd_b;
  logic [31:0] src_b;
  logic [4:0]  write_reg;
  logic [31:0] alu_result;

  logic is_mult;
  logic is_multu;
  logic is_mfhi;
  logic is_mflo;
  logic md_op;
  logic md_start;
  logic busy;

  md_state_t   state_reg,  state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [63:0] mcand_reg,  mcand_next;
  logic [31:0] mplier_reg, mplier_next;
  logic [63:0] acc_reg,    acc_next;
  logic        neg_reg,    neg_next;
  logic [31:0] hi_reg,     hi_next;
  logic [31:0] lo_reg,     lo_next;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] acc_sum;
  logic [63:0] product_final;
  logic [63:0] pp [BITS_PER_CYCLE];

  // Operand forwarding; code 11 falls back to the register-file value.
  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUOutM;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUOutM;
      default: fwd_b = RD2E;
    endcase
  end

  assign src_b     = ALUSrcE ? SignImmE : fwd_b;
  assign write_reg = RegDstE ? RdE : RtE;

  assign is_mult = (ALUControlE == OP_MULT);
  assign is_mfhi = (ALUControlE == OP_MFHI);
  assign is_mflo = (ALUControlE == OP_MFLO);
`ifdef MD_UNSIGNED_EN
  localparam logic [3:0] OP_MULTU = 4'b1011;
  assign is_multu = (ALUControlE == OP_MULTU);
`else
  assign is_multu = 1'b0;
`endif

  assign busy     = (state_reg == ST_BUSY);
  assign md_op    = is_mult | is_multu | is_mfhi | is_mflo;
  assign StallMdE = busy & md_op;
  assign md_start = (is_mult | is_multu) & ~busy;

  always_comb begin
    alu_result = 32'd0;
    case (ALUControlE)
      OP_AND:  alu_result = src_a & src_b;
      OP_OR:   alu_result = src_a | src_b;
      OP_XOR:  alu_result = src_a ^ src_b;
      OP_NOR:  alu_result = ~(src_a | src_b);
      OP_ADD:  alu_result = src_a + src_b;
      OP_SUB:  alu_result = src_a - src_b;
      OP_SLT:  alu_result = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
      OP_MFHI: alu_result = hi_reg;
      OP_MFLO: alu_result = lo_reg;
      default: alu_result = 32'd0;
    endcase
  end

  // Signed MULT works on magnitudes; the sign is restored on the final product.
  assign mag_a = (is_mult && src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign mag_b = (is_mult && fwd_b[31]) ? (~fwd_b + 32'd1) : fwd_b;

  genvar gi;
  generate
    for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
      assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : 64'd0;
    end
  endgenerate

  always_comb begin
    acc_sum = acc_reg;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      acc_sum = acc_sum + pp[k];
    end
  end

  assign product_final = neg_reg ? (~acc_sum + 64'd1) : acc_sum;

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    neg_next    = neg_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    case (state_reg)
      ST_IDLE: begin
        if (md_start) begin
          state_next  = ST_BUSY;
          count_next  = '0;
          mcand_next  = {32'd0, mag_a};
          mplier_next = mag_b;
          acc_next    = 64'd0;
          neg_next    = is_mult & (src_a[31] ^ fwd_b[31]);
        end
      end
      ST_BUSY: begin
        acc_next    = acc_sum;
        mcand_next  = mcand_reg << BITS_PER_CYCLE;
        mplier_next = mplier_reg >> BITS_PER_CYCLE;
        count_next  = count_reg + CW'(1);
        if (count_reg == LAST_COUNT) begin
          state_next = ST_IDLE;
          count_next = '0;
          hi_next    = product_final[63:32];
          lo_next    = product_final[31:0];
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      mcand_reg  <= 64'd0;
      mplier_reg <= 32'd0;
      acc_reg    <= 64'd0;
      neg_reg    <= 1'b0;
      hi_reg     <= HILO_RST;
      lo_reg     <= HILO_RST;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      neg_reg    <= neg_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
    end
  end

  // A stalled multiply-unit instruction becomes a fully zeroed bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUOutM    <= 32'd0;
      WriteDataM <= 32'd0;
      WriteRegM  <= 5'd0;
    end else if (StallMdE) begin
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUOutM    <= 32'd0;
      WriteDataM <= 32'd0;
      WriteRegM  <= 5'd0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemtoRegM  <= MemtoRegE;
      MemWriteM  <= MemWriteE;
      ALUOutM    <= alu_result;
      WriteDataM <= fwd_b;
      WriteRegM  <= write_reg;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: vector table, multi-cycle multiply/reset sequences and random traffic vs. a reference model.
module tb_ex_mem_stage;

  localparam int          BPC         = 1;
  localparam int          TB_L        = 32 / BPC;
  localparam logic [31:0] TB_HILO_RST = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, SignImmE, ResultW;
  logic [4:0]  RtE, RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        RegWriteM, MemtoRegM, MemWriteM, StallMdE;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;

  always #5 clk = ~clk;

  ex_mem_stage #(.BITS_PER_CYCLE(BPC), .HILO_RST(TB_HILO_RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .RtE(RtE), .RdE(RdE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .StallMdE(StallMdE)
  );

  typedef struct {
    logic        rw, m2r, mw, alusrc, regdst;
    logic [3:0]  op;
    logic [31:0] rd1, rd2, imm, resw;
    logic [4:0]  rt, rd;
    logic [1:0]  fa, fb;
  } txn_t;

  typedef struct {
    txn_t        t;
    logic [31:0] exp_alu;
    logic [31:0] exp_wd;
    logic [4:0]  exp_wr;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m_rw, m_m2r, m_mw;
  logic [31:0] m_alu, m_wd;
  logic [4:0]  m_wr;
  logic [31:0] r_hi, r_lo;
  int          rem;
  logic [63:0] pend;
  logic        last_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic [3:0] op, input logic [31:0] rd1, input logic [31:0] rd2);
    txn_t t;
    t.rw = 1'b1; t.m2r = 1'b0; t.mw = 1'b0; t.alusrc = 1'b0; t.regdst = 1'b1;
    t.op = op; t.rd1 = rd1; t.rd2 = rd2; t.imm = 32'd0; t.resw = 32'd0;
    t.rt = 5'd3; t.rd = 5'd9; t.fa = 2'b00; t.fb = 2'b00;
    return t;
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    logic r;
    r = (op == 4'h8);
`ifdef MD_UNSIGNED_EN
    r = r || (op == 4'hB);
`endif
    return r;
  endfunction

  function automatic logic is_md(input logic [3:0] op);
    return is_mul(op) || (op == 4'h9) || (op == 4'hA);
  endfunction

  function automatic logic [63:0] product(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    if (op == 4'hB) return {32'd0, a} * {32'd0, b};
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] f, input logic [31:0] reg_val, input logic [31:0] resw);
    if (f == 2'b01) return resw;
    if (f == 2'b10) return m_alu;
    return reg_val;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h3: return a ^ b;
      4'hC: return ~(a | b);
      4'h2: return a + b;
      4'h6: return a - b;
      4'h7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h9: return r_hi;
      4'hA: return r_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_rw = 1'b0; m_m2r = 1'b0; m_mw = 1'b0;
    m_alu = 32'd0; m_wd = 32'd0; m_wr = 5'd0;
    r_hi = TB_HILO_RST; r_lo = TB_HILO_RST;
    rem = 0; pend = 64'd0;
  endtask

  task automatic apply(input txn_t t);
    RegWriteE = t.rw; MemtoRegE = t.m2r; MemWriteE = t.mw;
    ALUSrcE = t.alusrc; RegDstE = t.regdst; ALUControlE = t.op;
    RD1E = t.rd1; RD2E = t.rd2; SignImmE = t.imm; ResultW = t.resw;
    RtE = t.rt; RdE = t.rd; ForwardAE = t.fa; ForwardBE = t.fb;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_regwrite"}, 32'(RegWriteM), 32'd0);
    chk({tag, "_memtoreg"}, 32'(MemtoRegM), 32'd0);
    chk({tag, "_memwrite"}, 32'(MemWriteM), 32'd0);
    chk({tag, "_aluout"}, ALUOutM, 32'd0);
    chk({tag, "_writedata"}, WriteDataM, 32'd0);
    chk({tag, "_writereg"}, 32'(WriteRegM), 32'd0);
  endtask

  // One clock of traffic: predict, clock, compare, then advance the model.
  task automatic run_cycle(input txn_t t);
    logic [31:0] a, b, sb, n_alu, n_wd;
    logic        exp_stall, n_rw, n_m2r, n_mw;
    logic [4:0]  n_wr;
    apply(t);
    #2;
    a = fwd(t.fa, t.rd1, t.resw);
    b = fwd(t.fb, t.rd2, t.resw);
    sb = t.alusrc ? t.imm : b;
    exp_stall = (rem > 0) && is_md(t.op);
    chk("stall", 32'(StallMdE), 32'(exp_stall));
    last_stall = StallMdE;
    if (exp_stall) begin
      n_rw = 1'b0; n_m2r = 1'b0; n_mw = 1'b0; n_alu = 32'd0; n_wd = 32'd0; n_wr = 5'd0;
    end else begin
      n_rw = t.rw; n_m2r = t.m2r; n_mw = t.mw;
      n_alu = ref_alu(t.op, a, sb);
      n_wd = b;
      n_wr = t.regdst ? t.rd : t.rt;
    end
    @(posedge clk);
    #1;
    m_rw = n_rw; m_m2r = n_m2r; m_mw = n_mw; m_alu = n_alu; m_wd = n_wd; m_wr = n_wr;
    if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        r_hi = pend[63:32];
        r_lo = pend[31:0];
      end
    end else if (is_mul(t.op)) begin
      pend = product(t.op, a, b);
      rem = TB_L;
    end
    chk("regwrite_m", 32'(RegWriteM), 32'(m_rw));
    chk("memtoreg_m", 32'(MemtoRegM), 32'(m_m2r));
    chk("memwrite_m", 32'(MemWriteM), 32'(m_mw));
    chk("aluout_m", ALUOutM, m_alu);
    chk("writedata_m", WriteDataM, m_wd);
    chk("writereg_m", 32'(WriteRegM), 32'(m_wr));
  endtask

  // Repeat an instruction until it is no longer stalled; n = stalled cycles seen.
  task automatic drain(input txn_t t, output int n);
    n = 0;
    for (int g = 0; g < 200; g++) begin
      run_cycle(t);
      if (!last_stall) break;
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[15];
    txn_t t;
    int   n;

    vt[0].t  = mk(4'h2, 32'd5, 32'd100); vt[0].t.fb = 2'b01; vt[0].t.resw = 32'd7;
    vt[0].exp_alu = 32'd12; vt[0].exp_wd = 32'd7; vt[0].exp_wr = 5'd9;
    vt[1].t  = mk(4'h7, 32'hFFFF_FFFF, 32'd1);
    vt[1].exp_alu = 32'd1; vt[1].exp_wd = 32'd1; vt[1].exp_wr = 5'd9;
    vt[2].t  = mk(4'h6, 32'd0, 32'd1);
    vt[2].exp_alu = 32'hFFFF_FFFF; vt[2].exp_wd = 32'd1; vt[2].exp_wr = 5'd9;
    vt[3].t  = mk(4'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    vt[3].exp_alu = 32'h00F0_00F0; vt[3].exp_wd = 32'h0FF0_0FF0; vt[3].exp_wr = 5'd9;
    vt[4].t  = mk(4'h1, 32'h0F0F_0000, 32'h0000_00F0);
    vt[4].exp_alu = 32'h0F0F_00F0; vt[4].exp_wd = 32'h0000_00F0; vt[4].exp_wr = 5'd9;
    vt[5].t  = mk(4'h3, 32'hFFFF_0000, 32'h0F0F_0F0F);
    vt[5].exp_alu = 32'hF0F0_0F0F; vt[5].exp_wd = 32'h0F0F_0F0F; vt[5].exp_wr = 5'd9;
    vt[6].t  = mk(4'hC, 32'd0, 32'h0F0F_0F0F);
    vt[6].exp_alu = 32'hF0F0_F0F0; vt[6].exp_wd = 32'h0F0F_0F0F; vt[6].exp_wr = 5'd9;
    vt[7].t  = mk(4'h2, 32'hFFFF_FFFF, 32'd2);
    vt[7].exp_alu = 32'd1; vt[7].exp_wd = 32'd2; vt[7].exp_wr = 5'd9;
    vt[8].t  = mk(4'h7, 32'd1, 32'hFFFF_FFFF);
    vt[8].exp_alu = 32'd0; vt[8].exp_wd = 32'hFFFF_FFFF; vt[8].exp_wr = 5'd9;
    vt[9].t  = mk(4'h2, 32'd10, 32'd99); vt[9].t.imm = 32'hFFFF_FFFC; vt[9].t.alusrc = 1'b1; vt[9].t.regdst = 1'b0;
    vt[9].exp_alu = 32'd6; vt[9].exp_wd = 32'd99; vt[9].exp_wr = 5'd3;
    vt[10].t = mk(4'h2, 32'd1000, 32'd1); vt[10].t.fa = 2'b10;
    vt[10].exp_alu = 32'd7; vt[10].exp_wd = 32'd1; vt[10].exp_wr = 5'd9;
    vt[11].t = mk(4'h2, 32'd20, 32'd22); vt[11].t.fa = 2'b11; vt[11].t.resw = 32'd500;
    vt[11].exp_alu = 32'd42; vt[11].exp_wd = 32'd22; vt[11].exp_wr = 5'd9;
    vt[12].t = mk(4'h4, 32'd3, 32'd4);
    vt[12].exp_alu = 32'd0; vt[12].exp_wd = 32'd4; vt[12].exp_wr = 5'd9;
    vt[13].t = mk(4'h6, 32'd50, 32'd9); vt[13].t.fb = 2'b10;
    vt[13].exp_alu = 32'd50; vt[13].exp_wd = 32'd0; vt[13].exp_wr = 5'd9;
    vt[14].t = mk(4'h7, 32'd5, 32'd5); vt[14].t.fb = 2'b11; vt[14].t.resw = 32'd77;
    vt[14].exp_alu = 32'd0; vt[14].exp_wd = 32'd5; vt[14].exp_wr = 5'd9;

    rst_n = 1'b0;
    apply(mk(4'h4, 32'd0, 32'd0));
    model_reset();
    last_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("por");
    #2 rst_n = 1'b1;

    run_cycle(mk(4'hA, 32'd0, 32'd0));
    chk("por_mflo", ALUOutM, TB_HILO_RST);
    run_cycle(mk(4'h9, 32'd0, 32'd0));
    chk("por_mfhi", ALUOutM, TB_HILO_RST);

    for (int i = 0; i < 15; i++) begin
      run_cycle(vt[i].t);
      chk($sformatf("vec%0d_alu", i), ALUOutM, vt[i].exp_alu);
      chk($sformatf("vec%0d_wd", i), WriteDataM, vt[i].exp_wd);
      chk($sformatf("vec%0d_wr", i), 32'(WriteRegM), 32'(vt[i].exp_wr));
    end

    // -3 * 7 with a dependent MFLO right behind it
    run_cycle(mk(4'h8, 32'hFFFF_FFFD, 32'd7));
    drain(mk(4'hA, 32'd0, 32'd0), n);
    chk("mult_stall_cycles", 32'(n), 32'(TB_L));
    chk("mult_mflo", ALUOutM, 32'hFFFF_FFEB);
    run_cycle(mk(4'h9, 32'd0, 32'd0));
    chk("mult_mfhi", ALUOutM, 32'hFFFF_FFFF);

    run_cycle(mk(4'h8, 32'h8000_0000, 32'h8000_0000));
    drain(mk(4'h9, 32'd0, 32'd0), n);
    chk("minint_mfhi", ALUOutM, 32'h4000_0000);
    run_cycle(mk(4'hA, 32'd0, 32'd0));
    chk("minint_mflo", ALUOutM, 32'd0);

    // Independent ALU work while the multiplier is busy
    run_cycle(mk(4'h8, 32'd1000, 32'd1000));
    run_cycle(mk(4'h2, 32'd2, 32'd2));
    chk("busy_add_stall", 32'(last_stall), 32'd0);
    chk("busy_add_result", ALUOutM, 32'd4);
    drain(mk(4'hA, 32'd0, 32'd0), n);
    chk("busy_mflo", ALUOutM, 32'h000F_4240);

    // Back-to-back MULT: second one waits for the first to finish
    run_cycle(mk(4'h8, 32'd5, 32'd6));
    drain(mk(4'h8, 32'd7, 32'd8), n);
    chk("b2b_mult_stall", 32'(n), 32'(TB_L));
    drain(mk(4'hA, 32'd0, 32'd0), n);
    chk("b2b_mflo_stall", 32'(n), 32'(TB_L));
    chk("b2b_mflo", ALUOutM, 32'd56);

    // Reset in busy cycle 10 aborts the multiply
    run_cycle(mk(4'h8, 32'd123456, 32'hFFFF_FCEB));
    for (int i = 0; i < 10; i++) run_cycle(mk(4'h2, 32'd2, 32'd2));
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    run_cycle(mk(4'h9, 32'd0, 32'd0));
    chk("midrst_mfhi_stall", 32'(last_stall), 32'd0);
    chk("midrst_mfhi", ALUOutM, TB_HILO_RST);
    run_cycle(mk(4'hA, 32'd0, 32'd0));
    chk("midrst_mflo", ALUOutM, TB_HILO_RST);

`ifdef MD_UNSIGNED_EN
    run_cycle(mk(4'hB, 32'hFFFF_FFFF, 32'd2));
    drain(mk(4'h9, 32'd0, 32'd0), n);
    chk("multu_stall", 32'(n), 32'(TB_L));
    chk("multu_mfhi", ALUOutM, 32'd1);
    run_cycle(mk(4'hA, 32'd0, 32'd0));
    chk("multu_mflo", ALUOutM, 32'hFFFF_FFFE);
`else
    run_cycle(mk(4'hB, 32'hFFFF_FFFF, 32'd2));
    chk("op1011_result", ALUOutM, 32'd0);
    run_cycle(mk(4'h9, 32'd0, 32'd0));
    chk("op1011_no_stall", 32'(last_stall), 32'd0);
    chk("op1011_hi", ALUOutM, TB_HILO_RST);
`endif

    for (int i = 0; i < 400; i++) begin
      t = mk(4'($urandom_range(0, 15)), $urandom, $urandom);
      if ($urandom_range(0, 5) == 0) t.op = 4'h8;
      if ($urandom_range(0, 3) == 0) t.rd1 = 32'($signed($urandom_range(0, 40)) - 20);
      if ($urandom_range(0, 3) == 0) t.rd2 = 32'($signed($urandom_range(0, 40)) - 20);
      t.imm = $urandom; t.resw = $urandom;
      t.rw = 1'($urandom); t.m2r = 1'($urandom); t.mw = 1'($urandom);
      t.alusrc = 1'($urandom); t.regdst = 1'($urandom);
      t.rt = 5'($urandom); t.rd = 5'($urandom);
      t.fa = 2'($urandom); t.fb = 2'($urandom);
      run_cycle(t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register. Sits directly upstream of the MEM/WB stage and drives its RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM and WriteRegM inputs.
- Contains the operand forwarding muxes, the ALU and the destination-register mux.
- Contains an iterative signed multiplier with HI/LO registers; it requests a stall while a dependent MULT/MFHI/MFLO cannot proceed.

Parameters:
- BITS_PER_CYCLE, 1: multiplier bits retired per clock. Legal values 1, 2, 4. Multiply latency L = 32/BITS_PER_CYCLE cycles.
- HILO_RST, 32'h0: reset value of HI and LO.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- RegWriteE  in  1  register-write control from ID/EX
- MemtoRegE  in  1  load-result select from ID/EX
- MemWriteE  in  1  store enable from ID/EX
- ALUSrcE  in  1  1: B operand = SignImmE
- RegDstE  in  1  1: destination = RdE, 0: destination = RtE
- ALUControlE  in  4  operation code (see Behaviour)
- RD1E  in  32  register-file read data A
- RD2E  in  32  register-file read data B
- SignImmE  in  32  sign-extended immediate
- RtE  in  5  rt field
- RdE  in  5  rd field
- ForwardAE  in  2  00: RD1E, 01: ResultW, 10: ALUOutM (internal register)
- ForwardBE  in  2  same encoding, applied to RD2E
- ResultW  in  32  writeback result
- RegWriteM  out  1  registered control
- MemtoRegM  out  1  registered control
- MemWriteM  out  1  registered control
- ALUOutM  out  32  registered ALU result
- WriteDataM  out  32  registered forwarded B operand (pre-ALUSrc mux)
- WriteRegM  out  5  registered destination register
- StallMdE  out  1  combinational stall request to the hazard unit

Behaviour:
- Reset (rst_n low, asynchronous): all M outputs 0, HI = LO = HILO_RST, busy = 0, iteration counter = 0. A reset mid-multiply aborts it; no HI/LO update occurs.
- ForwardAE/ForwardBE = 11: treated as 00.
- SrcBE = ALUSrcE ? SignImmE : forwarded B.
- WriteRegE = RegDstE ? RdE : RtE.
- ALU opcodes:
  - 0000 AND, 0001 OR, 0011 XOR, 1100 NOR
  - 0010 ADD, 0110 SUB: 32-bit wrap, no overflow trap
  - 0111 SLT: signed, result 1 or 0
  - 1000 MULT: ALU result 0; starts the multiplier
  - 1001 MFHI: result = HI
  - 1010 MFLO: result = LO
  - all other codes: result 0, no side effects
- EX/MEM register loads every cycle; there is no enable.
  - If StallMdE = 1, it loads a bubble: RegWriteM = MemtoRegM = MemWriteM = 0, data fields don't-care (the bench expects 0).
- StallMdE = busy && ALUControlE is MULT, MFHI or MFLO. Other instructions flow normally while busy.
- Multiplier operation:
  - MULT in EX with busy = 0 latches the forwarded A and B at that edge; busy goes 1 the next cycle.
  - The multiplier is signed: it multiplies magnitudes and negates the 64-bit product if the operand signs differ.
  - After L busy cycles, HI/LO are written with the 64-bit product and busy drops at the same edge.
  - An MFHI/MFLO presented in the first non-busy cycle reads the new value.
- Back-to-back MULT: the second MULT stalls until busy falls, then starts on the following edge.
- Edge cases: a product of 0x80000000 × 0x80000000 gives HI = 0x40000000, LO = 0. The counter wraps only through reset or completion.

Optional Feature:
- Macro: MD_UNSIGNED_EN.
- Defined: opcode 1011 = MULTU. Same timing and stall rules as MULT, but the product is unsigned with no sign correction.
- Undefined: 1011 is an unused code (result 0, no multiplier start, no stall).

Test Plan:
- Reset: hold rst_n low mid-run -> all M outputs 0 immediately, HI = LO = 0. Release rst_n, then MFLO -> ALUOutM = 0.
- ALU and forwarding: ADD with RD1E = 5, ForwardBE = 01, ResultW = 7 -> ALUOutM = 12, WriteDataM = 7. SLT with A = 0xFFFFFFFF, B = 1 -> 1. SUB 0 − 1 -> 0xFFFFFFFF.
- Multiply (BITS_PER_CYCLE = 1): MULT A = −3, B = 7, then MFLO issued next cycle -> StallMdE high for 32 cycles with bubbles in M. MFLO then gives ALUOutM = 0xFFFFFFEB and MFHI gives 0xFFFFFFFF.
- Independent flow while busy: ADD 2 + 2 issued during a multiply -> StallMdE = 0, ALUOutM = 4 on the next edge. HI/LO are unchanged until completion.
- Reset mid-multiply at busy cycle 10 -> busy = 0. A following MFHI sees HILO_RST with no stall.
- MD_UNSIGNED_EN: MULTU 0xFFFFFFFF × 2 -> HI = 1, LO = 0xFFFFFFFE. Without the macro, the same opcode gives ALUOutM = 0 and no stall.
